// File: rtl/regfile_pkg.sv
// Shared widths, FSM encoding and port-slice helpers for the multi-port register file.
`ifndef REGFILE_PKG_SV
`define REGFILE_PKG_SV

// Port k of a flattened multi-port bus of element width w.
`define RF_SLICE(vec, k, w) vec[(k)*(w) +: (w)]

package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    // True when an address names a real, writable register.
    function automatic logic rf_addr_ok(input int unsigned addr, input int unsigned depth,
                                        input bit zero_r0);
        return (addr < depth) && !(zero_r0 && (addr == 0));
    endfunction

endpackage

`endif

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reserve, cleared by writes and flush.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 32,
    parameter int NREAD   = 2,
    parameter int NWRITE  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [NREAD*ADDR_W-1:0]  ra,
    input  logic [NREAD-1:0]         bypass_hit,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*ADDR_W-1:0] wa,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsva,
    input  logic                     flush,
    output logic [NREAD-1:0]         rrdy
);

    logic [DEPTH-1:0] pend_q, pend_d;

    // Later assignments win: flush clear, then write clear, then reserve set.
    always_comb begin
        pend_d = pend_q;
        if (run) begin
            if (flush) begin
                pend_d = '0;
            end
            for (int j = 0; j < NWRITE; j++) begin
                if (we[j] && rf_addr_ok(32'(`RF_SLICE(wa, j, ADDR_W)), DEPTH, ZERO_R0 != 0)) begin
                    pend_d[`RF_SLICE(wa, j, ADDR_W)] = 1'b0;
                end
            end
            if (rsv && rf_addr_ok(32'(rsva), DEPTH, ZERO_R0 != 0)) begin
                pend_d[rsva] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rrdy = '0;
        for (int k = 0; k < NREAD; k++) begin
            if (run) begin
                if (!rf_addr_ok(32'(`RF_SLICE(ra, k, ADDR_W)), DEPTH, ZERO_R0 != 0) || bypass_hit[k]) begin
                    rrdy[k] = 1'b1;
                end else begin
                    rrdy[k] = !pend_q[`RF_SLICE(ra, k, ADDR_W)];
                end
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write bypass, fixed-priority writes, hardwired R0,
// pending-write scoreboard and a post-reset clear sweep.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 32,
    parameter int NREAD   = 2,
    parameter int NWRITE  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                     RegisterFileMP_CLK,
    input  logic                     RegisterFileMP_RST,
    input  logic [NREAD*ADDR_W-1:0]  RegisterFileMP_RA,
    output logic [NREAD*DATA_W-1:0]  RegisterFileMP_RD,
    output logic [NREAD-1:0]         RegisterFileMP_RRDY,
    input  logic [NWRITE-1:0]        RegisterFileMP_WE,
    input  logic [NWRITE*ADDR_W-1:0] RegisterFileMP_WA,
    input  logic [NWRITE*DATA_W-1:0] RegisterFileMP_WD,
    input  logic                     RegisterFileMP_RSV,
    input  logic [ADDR_W-1:0]        RegisterFileMP_RSVA,
    input  logic                     RegisterFileMP_FLUSH,
    output logic                     RegisterFileMP_BUSY
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              run;
    logic [NREAD-1:0]  bypass_hit;

    assign run                 = (state_q == ST_RUN) && !RegisterFileMP_RST;
    assign RegisterFileMP_BUSY = !run;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == ST_CLEAR) begin
            idx_d = idx_q + (ADDR_W + 1)'(1);
            if (idx_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge RegisterFileMP_CLK) begin
        if (RegisterFileMP_RST) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: storage has no reset branch so it maps onto RAM; the sweep clears it instead.
    // Ports are visited in ascending order, so the highest enabled port lands last and wins.
    always_ff @(posedge RegisterFileMP_CLK) begin
        if (!RegisterFileMP_RST && state_q == ST_CLEAR) begin
            mem_q[idx_q[ADDR_W-1:0]] <= '0;
        end else if (run) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (RegisterFileMP_WE[j] &&
                    rf_addr_ok(32'(`RF_SLICE(RegisterFileMP_WA, j, ADDR_W)), DEPTH, ZERO_R0 != 0)) begin
                    mem_q[`RF_SLICE(RegisterFileMP_WA, j, ADDR_W)] <= `RF_SLICE(RegisterFileMP_WD, j, DATA_W);
                end
            end
        end
    end

    always_comb begin
        RegisterFileMP_RD = '0;
        bypass_hit        = '0;
        for (int k = 0; k < NREAD; k++) begin
            if (run && rf_addr_ok(32'(`RF_SLICE(RegisterFileMP_RA, k, ADDR_W)), DEPTH, ZERO_R0 != 0)) begin
                `RF_SLICE(RegisterFileMP_RD, k, DATA_W) = mem_q[`RF_SLICE(RegisterFileMP_RA, k, ADDR_W)];
                for (int j = 0; j < NWRITE; j++) begin
                    if (RegisterFileMP_WE[j] &&
                        `RF_SLICE(RegisterFileMP_WA, j, ADDR_W) == `RF_SLICE(RegisterFileMP_RA, k, ADDR_W)) begin
                        `RF_SLICE(RegisterFileMP_RD, k, DATA_W) = `RF_SLICE(RegisterFileMP_WD, j, DATA_W);
                        bypass_hit[k] = 1'b1;
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .NREAD   (NREAD),
        .NWRITE  (NWRITE),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk        (RegisterFileMP_CLK),
        .rst        (RegisterFileMP_RST),
        .run        (run),
        .ra         (RegisterFileMP_RA),
        .bypass_hit (bypass_hit),
        .we         (RegisterFileMP_WE),
        .wa         (RegisterFileMP_WA),
        .rsv        (RegisterFileMP_RSV),
        .rsva       (RegisterFileMP_RSVA),
        .flush      (RegisterFileMP_FLUSH),
        .rrdy       (RegisterFileMP_RRDY)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a 32-entry and a 24-entry instance share stimulus.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ra;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        rsv;
    logic [4:0]  rsva;
    logic        flush;

    logic [63:0] rd32, rd24;
    logic [1:0]  rrdy32, rrdy24;
    logic        busy32, busy24;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_mp dut32 (
        .RegisterFileMP_CLK   (clk),
        .RegisterFileMP_RST   (rst),
        .RegisterFileMP_RA    (ra),
        .RegisterFileMP_RD    (rd32),
        .RegisterFileMP_RRDY  (rrdy32),
        .RegisterFileMP_WE    (we),
        .RegisterFileMP_WA    (wa),
        .RegisterFileMP_WD    (wd),
        .RegisterFileMP_RSV   (rsv),
        .RegisterFileMP_RSVA  (rsva),
        .RegisterFileMP_FLUSH (flush),
        .RegisterFileMP_BUSY  (busy32)
    );

    register_file_mp #(.DEPTH(24)) dut24 (
        .RegisterFileMP_CLK   (clk),
        .RegisterFileMP_RST   (rst),
        .RegisterFileMP_RA    (ra),
        .RegisterFileMP_RD    (rd24),
        .RegisterFileMP_RRDY  (rrdy24),
        .RegisterFileMP_WE    (we),
        .RegisterFileMP_WA    (wa),
        .RegisterFileMP_WD    (wd),
        .RegisterFileMP_RSV   (rsv),
        .RegisterFileMP_RSVA  (rsva),
        .RegisterFileMP_FLUSH (flush),
        .RegisterFileMP_BUSY  (busy24)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled one unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        ra = {a1, a0};
        #1;
    endtask

    task automatic idle_inputs();
        we    = '0;
        wa    = '0;
        wd    = '0;
        rsv   = 1'b0;
        rsva  = '0;
        flush = 1'b0;
    endtask

    int n32, n24;

    initial begin
        rst = 1'b1;
        ra  = '0;
        idle_inputs();

        // Reset held for two edges; outputs forced quiet.
        tick();
        set_ra(5'd1, 5'd2);
        check("rst_busy", 32'(busy32), 32'd1);
        check("rst_rd", rd32[31:0], 32'h0);
        check("rst_rrdy", 32'(rrdy32), 32'd0);
        tick();
        rst = 1'b0;

        // Sweep length; a write to R5 mid-sweep must be dropped.
        n32 = 0;
        n24 = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy32) n32++;
            if (busy24) n24++;
            if (i == 10) begin
                we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF};
            end else begin
                idle_inputs();
            end
            tick();
        end
        check("sweep_cycles_32", 32'(n32), 32'd32);
        check("sweep_cycles_24", 32'(n24), 32'd24);
        check("busy_after_sweep", 32'(busy32), 32'd0);

        for (int a = 0; a < 32; a++) begin
            set_ra(5'(a), 5'(31 - a));
            check($sformatf("clear_r%0d", a), rd32[31:0], 32'h0);
            check($sformatf("clear_rrdy_r%0d", a), 32'(rrdy32), 32'd3);
        end

        // Same-address writes on both ports: port 1 wins, bypass shows it at once.
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22222222, 32'h11111111};
        set_ra(5'd7, 5'd0);
        check("bypass_prio", rd32[31:0], 32'h22222222);
        check("bypass_rrdy", 32'(rrdy32[0]), 32'd1);
        tick();
        idle_inputs();
        set_ra(5'd7, 5'd0);
        check("mem7_prio", rd32[31:0], 32'h22222222);

        // R0 and out-of-range on the 24-entry instance; R30 is real storage in the 32-entry one.
        we = 2'b11; wa = {5'd30, 5'd0}; wd = {32'hFFFFFFFF, 32'hFFFFFFFF};
        set_ra(5'd0, 5'd30);
        check("r0_no_bypass", rd24[31:0], 32'h0);
        check("r30_no_bypass_24", rd24[63:32], 32'h0);
        tick();
        idle_inputs();
        set_ra(5'd0, 5'd30);
        check("r0_read_24", rd24[31:0], 32'h0);
        check("r30_read_24", rd24[63:32], 32'h0);
        check("r0_r30_rrdy_24", 32'(rrdy24), 32'd3);
        check("r0_read_32", rd32[31:0], 32'h0);
        check("r30_read_32", rd32[63:32], 32'hFFFFFFFF);
        rsv = 1'b1; rsva = 5'd0;
        tick();
        idle_inputs();
        set_ra(5'd0, 5'd30);
        check("r0_rsv_rrdy_24", 32'(rrdy24), 32'd3);
        check("r0_rsv_rrdy_32", 32'(rrdy32[0]), 32'd1);

        // Scoreboard on R9.
        rsv = 1'b1; rsva = 5'd9;
        set_ra(5'd9, 5'd0);
        check("rsv_same_cycle", 32'(rrdy32[0]), 32'd1);
        tick();
        idle_inputs();
        set_ra(5'd9, 5'd0);
        check("rsv_pending", 32'(rrdy32[0]), 32'd0);
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h00001234};
        set_ra(5'd9, 5'd0);
        check("wr_bypass_rrdy", 32'(rrdy32[0]), 32'd1);
        check("wr_bypass_rd", rd32[31:0], 32'h00001234);
        tick();
        idle_inputs();
        set_ra(5'd9, 5'd0);
        check("wr_cleared", 32'(rrdy32[0]), 32'd1);
        check("wr_data", rd32[31:0], 32'h00001234);
        we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h00005678, 32'h0};
        rsv = 1'b1; rsva = 5'd9;
        tick();
        idle_inputs();
        set_ra(5'd9, 5'd0);
        check("rsv_wr_pending", 32'(rrdy32[0]), 32'd0);
        check("rsv_wr_data", rd32[31:0], 32'h00005678);

        // Flush with a simultaneous reserve.
        rsv = 1'b1; rsva = 5'd3;
        tick();
        rsva = 5'd4;
        tick();
        idle_inputs();
        set_ra(5'd3, 5'd4);
        check("pend_r3_r4", 32'(rrdy32), 32'd0);
        flush = 1'b1; rsv = 1'b1; rsva = 5'd6;
        tick();
        idle_inputs();
        set_ra(5'd3, 5'd4);
        check("flush_r3_r4", 32'(rrdy32), 32'd3);
        set_ra(5'd6, 5'd9);
        check("flush_r6_kept", 32'(rrdy32[0]), 32'd0);
        check("flush_r9_cleared", 32'(rrdy32[1]), 32'd1);

        // Mid-operation reset: R12 written and reserved, then wiped.
        we = 2'b01; wa = {5'd0, 5'd12}; wd = {32'h0, 32'h0000ABCD};
        rsv = 1'b1; rsva = 5'd12;
        tick();
        idle_inputs();
        set_ra(5'd12, 5'd0);
        check("r12_written", rd32[31:0], 32'h0000ABCD);
        check("r12_pending", 32'(rrdy32[0]), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy32), 32'd1);
        check("midrst_rd", rd32[31:0], 32'h0);
        tick();
        rst = 1'b0;
        n32 = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy32) n32++;
            tick();
        end
        check("resweep_cycles", 32'(n32), 32'd32);
        set_ra(5'd12, 5'd6);
        check("r12_cleared", rd32[31:0], 32'h0);
        check("r12_rrdy", 32'(rrdy32[0]), 32'd1);
        check("r6_rrdy_after_rst", 32'(rrdy32[1]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Multi-port, parametrised register file for the pipelined MIPS datapath.
- Supports NREAD combinational read ports with write-to-read bypass, NWRITE write ports with fixed priority, and a hardwired-zero R0.
- Includes a per-register pending-write scoreboard so the hazard unit can stall on in-flight producers.
- After reset, clears storage with a one-register-per-cycle sweep FSM, so the array maps onto RAM without a wide reset fan-out.

Parameters:
- DATA_W, 32, data width of each register.
- ADDR_W, 5, register address width.
- DEPTH, 32, number of registers implemented; DEPTH <= 2**ADDR_W.
- NREAD, 2, number of read ports.
- NWRITE, 2, number of write ports; a higher index has higher priority.
- ZERO_R0, 1, when 1, register 0 reads as 0 and ignores writes and reserves.

Ports:
- RegisterFileMP_CLK  in  1  clock; all state updates on the rising edge.
- RegisterFileMP_RST  in  1  reset; one clock, synchronous, active-high.
- RegisterFileMP_RA  in  NREAD*ADDR_W  read addresses; port k uses slice k.
- RegisterFileMP_RD  out  NREAD*DATA_W  read data; port k uses slice k.
- RegisterFileMP_RRDY  out  NREAD  per read port: operand is valid (no outstanding producer).
- RegisterFileMP_WE  in  NWRITE  write enables.
- RegisterFileMP_WA  in  NWRITE*ADDR_W  write addresses.
- RegisterFileMP_WD  in  NWRITE*DATA_W  write data.
- RegisterFileMP_RSV  in  1  reserve: mark register RSVA as pending (issued producer).
- RegisterFileMP_RSVA  in  ADDR_W  reserve address.
- RegisterFileMP_FLUSH  in  1  clear all pending bits (pipeline flush).
- RegisterFileMP_BUSY  out  1  high while resetting or clearing; writes and reserves are ignored.

Behaviour:
- FSM states are CLEAR and RUN.
- Reset:
  - RST=1 at an edge forces state=CLEAR, sweep index=0 and all pending bits=0.
  - While RST=1: BUSY=1, RD=0, RRDY=0.
  - Reset asserted mid-sweep or in RUN restarts the sweep at index 0.
- CLEAR:
  - Each edge with RST=0 writes 0 to mem[index] and increments index.
  - When index==DEPTH-1 is written, the next state is RUN.
  - The sweep takes exactly DEPTH cycles after RST deasserts.
  - BUSY=1, RD=0, RRDY=0 throughout; WE, RSV and FLUSH are ignored.
- RUN:
  - BUSY=0.
  - Reads are combinational (0-cycle latency).
  - For port k, RD is selected in this order:
    - RA==0 with ZERO_R0=1: RD=0.
    - RA>=DEPTH: RD=0.
    - Otherwise, if any write port j has WE[j]=1 and WA[j]==RA: RD=WD of the highest such j (bypass).
    - Otherwise RD=mem[RA].
- RRDY[k]=1 when any of the following holds:
  - RA==0 with ZERO_R0=1.
  - RA>=DEPTH.
  - A bypass hit exists on RA.
  - pending[RA]==0.
  - RRDY reflects state before the current cycle's reserve.
- Writes:
  - At the edge, each enabled port writes mem[WA]=WD.
  - If multiple ports target the same address, the highest index wins.
  - Writes to R0 (ZERO_R0=1) or to addresses >=DEPTH are dropped.
  - A write clears pending[WA].
- Reserve: RSV=1 sets pending[RSVA] at the edge. Reserve to R0 (ZERO_R0=1) or to RSVA>=DEPTH is ignored.
- Simultaneous events, in priority order for pending (lowest to highest): FLUSH clear, then write clear, then reserve set.
  - A reserve and a write to the same address in one cycle: data is written and pending ends 1.
  - FLUSH with RSV: all pending bits clear except RSVA, which ends 1.
  - FLUSH does not affect data writes.
- Width rules:
  - No arithmetic on data.
  - Index counter is ADDR_W+1 bits to avoid wrap when DEPTH==2**ADDR_W.

Decomposition:
- Package regfile_pkg holds:
  - Default widths (DATA_W_DEF=32, ADDR_W_DEF=5).
  - The state encoding (ST_CLEAR=1'b0, ST_RUN=1'b1).
  - The read/write slice helper macros.
- Sub-module regfile_scoreboard (DEPTH pending bits plus reserve/write/flush update logic and RRDY lookup) is a natural split.
- Storage, bypass and the clear FSM stay in the top.

Test Plan:
- Reset sweep: pulse RST for 2 cycles, then hold 0.
  - BUSY stays 1 for exactly 32 cycles, then 0.
  - All 32 registers read 0.
  - A write of 0xDEADBEEF to R5 issued during the sweep is not retained.
- Bypass and port priority, in RUN:
  - WE=2'b11, WA0=WA1=7, WD0=0x11111111, WD1=0x22222222, RA0=7.
  - Same cycle: RD0=0x22222222.
  - Next cycle: mem[7] reads 0x22222222.
- R0 and out-of-range, with DEPTH=24:
  - Write 0xFFFFFFFF to R0 and to R30.
  - Reading R0 and R30 gives RD=0 and RRDY=1.
  - RSV to R0 leaves RRDY=1.
- Scoreboard:
  - RSV R9 gives RRDY=0 on R9 from the next cycle.
  - Write R9=0x1234: RRDY=1 and RD=0x1234 in the same cycle (bypass).
  - RSV and write to R9 in the same cycle: pending stays 1.
- Flush:
  - Reserve R3, R4, then FLUSH together with RSV R6.
  - Next cycle: RRDY for R3=1, R4=1, R6=0.
- Mid-operation reset:
  - Reserve R12 in RUN, then assert RST for one cycle.
  - The sweep restarts and R12 reads 0.
  - After the sweep, RRDY for R12=1.
